regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and register scoreboard for the 32x32 register file. Up to NREQ write-back sources (ALU, load unit, multicycle unit) compete for the register file's single write port. The block grants one source per cycle in round-robin order and drives the write port from registers. It also tracks pending destination registers so decode can stall on read-after-write hazards.

## Interface
- NREQ, 3, number of write-back requesters (2..4)
- XLEN, 32, data width
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-source write-back request
- req_rd  in  5*NREQ  destination register of source i at bits [5i+4:5i]
- req_data  in  XLEN*NREQ  write data of source i at bits [XLEN*i+XLEN-1:XLEN*i]
- gnt  out  NREQ  one-hot grant, combinational, at most one bit set
- wr_en  out  1  register file write enable (regWriteS)
- wr_rd  out  5  register file write address
- wr_data  out  XLEN  register file write data
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  5  destination of the issued instruction
- chk_rs1, chk_rs2  in  5 each  source registers of the instruction in decode
- busy  out  32  scoreboard, bit r set while register r has a pending write
- stall  out  1  combinational RAW hazard flag

## Operation
- Handshake: source i raises req[i] with req_rd/req_data stable and holds them until the cycle gnt[i]=1. That cycle is the transfer. The source drops or changes its request on the next cycle.
- Arbitration: rr_ptr (log2 NREQ bits) marks the highest-priority index. Search req starting at rr_ptr, ascending, wrapping modulo NREQ. The first set bit gets gnt.
  - After a grant to i, rr_ptr becomes (i+1) mod NREQ.
  - rr_ptr holds when there is no grant.
- Write port registers: on a posedge with gnt[i]=1, capture wr_rd=req_rd[i] and wr_data=req_data[i].
  - Set wr_en=1 unless req_rd[i]==0. An x0 request is granted and consumed but wr_en stays 0.
  - On a posedge with no grant, wr_en=0; wr_rd and wr_data hold.
- Scoreboard, evaluated on each posedge:
  - Clear busy[r] when a grant with rd=r≠0 is captured.
  - Set busy[r] when issue_valid=1 and issue_rd=r≠0.
  - Set and clear of the same r on the same edge: set wins (a new producer is pending).
  - busy[0] is constant 0.
- Hazard: stall = busy[chk_rs1] | busy[chk_rs2]. busy[0]=0 makes x0 never stall. stall does not depend on req.
- Duplicate issue to an already-busy r leaves busy[r]=1. The first write-back clears it; ordering of multiple producers is decode's responsibility.

## Timing
- Reset values:
  - gnt=0 (combinational from req; req must be 0 during rst)
  - wr_en=0, wr_rd=0, wr_data=0
  - busy=0, stall=0, rr_ptr=0
- Reset mid-operation: all state clears immediately. Captured writes not yet presented on wr_en are dropped. Sources must re-request after rst deasserts.
- Grant latency is 0 cycles: gnt is asserted in the same cycle as req if the source wins.
- Write latency: wr_en is high during the cycle after the grant edge. The register file commits it on the falling edge inside that cycle.
- Busy clears on the same edge that raises wr_en. A dependent read in that cycle sees stall=0 and reads the value the register file commits at the mid-cycle falling edge.
- Throughput is one write per cycle. Every requester is served within NREQ cycles of continuous assertion (starvation-free).

## Test plan
- Reset: assert rst with random inputs → wr_en=0, wr_rd=0, wr_data=0, busy=0, stall=0. Release rst, then req=3'b111 → first gnt=3'b001.
- Round-robin: hold req=3'b111 for 6 cycles → gnt sequence 001,010,100,001,010,100, and wr_en=1 in each following cycle with the matching rd/data.
- Single source: req[2]=1, rd=5, data=0xDEADBEEF → gnt=100 that cycle; next cycle wr_en=1, wr_rd=5, wr_data=0xDEADBEEF, rr_ptr=0.
- x0 write: req[0]=1, rd=0, data=0x1234 → gnt=001, and wr_en stays 0 the next cycle.
- Scoreboard: issue_valid with rd=7, then chk_rs1=7 → stall=1. Grant a write-back of rd=7 → busy[7]=0 and stall=0 in the wr_en cycle. chk_rs2=0 → stall=0 always.
- Set/clear collision: issue_valid with issue_rd=9 on the same edge as a captured grant with rd=9 → busy[9] remains 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port, with a
// per-register pending-write scoreboard that raises stall on read-after-write hazards.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 wr_en,
  output logic [4:0]           wr_rd,
  output logic [XLEN-1:0]      wr_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  output logic [31:0]          busy,
  output logic                 stall
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_rd_q, wr_rd_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [31:0]     busy_q, busy_d;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  // Search starts at rr_ptr and wraps; the first requester found wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = PW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  assign sel_rd   = req_rd[int'(gnt_idx)*5 +: 5];
  assign sel_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    if (gnt_any) begin
      rr_ptr_d  = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
      wr_en_d   = (sel_rd != 5'd0);
      wr_rd_d   = sel_rd;
      wr_data_d = sel_data;
      if (sel_rd != 5'd0) busy_d[sel_rd] = 1'b0;
    end
    // Applied after the clear so a newly issued producer keeps the register pending.
    if (issue_valid && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign stall   = busy_q[chk_rs1] | busy_q[chk_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a behavioural
// model of round-robin arbitration, the write port and the scoreboard.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic                 wr_en;
  logic [4:0]           wr_rd;
  logic [XLEN-1:0]      wr_data;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [4:0]           chk_rs1, chk_rs2;
  logic [31:0]          busy;
  logic                 stall;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rd(req_rd), .req_data(req_data),
    .gnt(gnt), .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Source-side stimulus state
  logic        src_req [NREQ];
  logic [4:0]  src_rd  [NREQ];
  logic [31:0] src_data[NREQ];

  // Reference model state
  int          m_rr;
  logic [31:0] m_busy;
  logic        m_wr_en;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_wr_data;
  int          last_g;

  // Outputs observed at the last mid-cycle sample
  logic [NREQ-1:0] obs_gnt;
  logic            obs_stall;
  logic [31:0]     obs_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_busy = '0; m_wr_en = 1'b0; m_wr_rd = '0; m_wr_data = '0;
  endtask

  // Called at posedge+1: drives inputs, checks at mid-cycle, advances the model.
  task automatic step();
    logic [NREQ-1:0] eg;
    int g;
    int idx;
    for (int i = 0; i < NREQ; i++) begin
      req[i]                = src_req[i];
      req_rd[5*i +: 5]      = src_rd[i];
      req_data[XLEN*i +: XLEN] = src_data[i];
    end
    if (rst) model_reset();
    #3;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (g < 0 && src_req[idx]) g = idx;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    obs_gnt = gnt; obs_stall = stall; obs_busy = busy;
    check("gnt",     32'(gnt),     32'(eg));
    check("stall",   32'(stall),   32'(m_busy[chk_rs1] | m_busy[chk_rs2]));
    check("wr_en",   32'(wr_en),   32'(m_wr_en));
    check("wr_rd",   32'(wr_rd),   32'(m_wr_rd));
    check("wr_data", wr_data,      m_wr_data);
    check("busy",    busy,         m_busy);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      last_g = -1;
    end else begin
      m_wr_en = 1'b0;
      if (g >= 0) begin
        m_wr_rd   = src_rd[g];
        m_wr_data = src_data[g];
        m_wr_en   = (src_rd[g] != 0);
        if (src_rd[g] != 0) m_busy[src_rd[g]] = 1'b0;
        m_rr = (g + 1) % NREQ;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      last_g = g;
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NREQ; i++) src_req[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    req = '0; req_rd = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_req[i] = 1'b0; src_rd[i] = '0; src_data[i] = '0;
    end
    model_reset();
    last_g = -1;
    @(posedge clk);
    #1;

    // Reset holds everything clear despite random inputs
    repeat (3) begin
      issue_valid = 1'($urandom); issue_rd = 5'($urandom);
      chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        src_rd[i] = 5'($urandom); src_data[i] = $urandom;
      end
      step();
      check("rst_busy", obs_busy, 32'h0);
    end
    rst = 1'b0; issue_valid = 1'b0; chk_rs1 = '0; chk_rs2 = '0;

    // Round robin under full load
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        src_req[i] = 1'b1; src_rd[i] = 5'(1 + i + 3*c); src_data[i] = $urandom;
      end
      step();
      check("rr_seq", 32'(obs_gnt), 32'(1 << (c % 3)));
      check("rr_wr_rd", 32'(wr_rd), 32'(1 + (c % 3) + 3*c));
    end

    // Single source 2
    clear_srcs();
    src_req[2] = 1'b1; src_rd[2] = 5'd5; src_data[2] = 32'hDEADBEEF;
    step();
    check("single_gnt", 32'(obs_gnt), 32'h4);
    check("single_wr_en", 32'(wr_en), 32'h1);
    check("single_wr_rd", 32'(wr_rd), 32'h5);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    for (int i = 0; i < NREQ; i++) src_req[i] = 1'b1;
    step();
    check("ptr_wrap_gnt", 32'(obs_gnt), 32'h1);

    // x0 write is consumed without enabling the write port
    clear_srcs();
    src_req[0] = 1'b1; src_rd[0] = 5'd0; src_data[0] = 32'h1234;
    step();
    check("x0_gnt", 32'(obs_gnt), 32'h1);
    check("x0_wr_en", 32'(wr_en), 32'h0);
    clear_srcs();

    // Scoreboard set, stall, clear on write-back
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    step();
    check("sb_stall_set", 32'(obs_stall), 32'h1);
    src_req[1] = 1'b1; src_rd[1] = 5'd7; src_data[1] = 32'hCAFE0007;
    step();
    clear_srcs();
    step();
    check("sb_wr_en", 32'(wr_en), 32'h0);
    check("sb_busy7", 32'(obs_busy[7]), 32'h0);
    check("sb_stall_clr", 32'(obs_stall), 32'h0);

    // Set wins over clear for the same register on the same edge
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    src_req[0] = 1'b1; src_rd[0] = 5'd9; src_data[0] = 32'h99;
    step();
    clear_srcs(); issue_valid = 1'b0; chk_rs1 = 5'd0; chk_rs2 = 5'd9;
    step();
    check("collide_busy9", 32'(obs_busy[9]), 32'h1);
    check("collide_stall", 32'(obs_stall), 32'h1);

    // Randomized traffic with a mid-run reset
    for (int c = 0; c < 400; c++) begin
      if (c == 200 || c == 201) begin
        rst = 1'b1;
        clear_srcs();
      end else begin
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (!src_req[i] || last_g == i) begin
            src_req[i]  = ($urandom_range(0, 99) < 60);
            src_rd[i]   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            src_data[i] = $urandom;
          end
        end
      end
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_rd    = 5'($urandom);
      chk_rs1     = 5'($urandom);
      chk_rs2     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
